// File: rtl/ioctl_ldr_bridge.sv
// ioctl download stream to core loader bridge: packs bytes into big-endian words, FIFO-buffers
// them, and drives the level wr/ack handshake. Optional checksum output with LDR_CHECKSUM_EN.
module ioctl_ldr_bridge #(
    parameter int         DEPTH = 8,
    parameter int         AW    = 20,
    parameter logic [7:0] IDX   = 8'h00
) (
    input  logic          clk_sys,
    input  logic          rstn,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          ldr_aen,
    output logic [AW-1:0] ldr_addr,
    output logic [15:0]   ldr_wdat,
    output logic [1:0]    ldr_be,
    output logic          ldr_wr,
    input  logic          ldr_ack,
    output logic          ldr_done
`ifdef LDR_CHECKSUM_EN
    ,
    output logic [15:0]   ldr_sum
`endif
);
    // state   | meaning
    // S_IDLE  | waiting for a matching download start
    // S_LOAD  | accepting and packing bytes
    // S_FLUSH | pushing a leftover even byte
    // S_DRAIN | waiting for FIFO empty and no outstanding write
    // S_DONE  | load complete, ldr_done set
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW - 1 + 16 + 2;

    state_t            state;
    logic              dl_q;
    logic              ack_q;
    logic              need_low;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [EW-1:0]     mem [DEPTH];

    logic              pend_v;
    logic [7:0]        pend;
    logic [AW-2:0]     pend_tag;

    logic              pend_v_n;
    logic [7:0]        pend_n;
    logic [AW-2:0]     pend_tag_n;
    logic [1:0]        n_push;
    logic [EW-1:0]     e0;
    logic [EW-1:0]     e1;
    logic [EW-1:0]     flush_e;
    logic [EW-1:0]     head;

    logic [AW-2:0]     byte_tag;
    logic              dl_start;
    logic              dl_fall;
    logic              accept;
    logic              pop;
    logic              issue;

    logic              unused_addr;
    assign unused_addr = ^ioctl_addr[24:AW];

    assign byte_tag   = ioctl_addr[AW-1:1];
    assign dl_start   = ioctl_download & ~dl_q & (ioctl_index == IDX);
    assign dl_fall    = ~ioctl_download & dl_q;
    assign accept     = (state == S_LOAD) & ioctl_wr & (ioctl_index == IDX);
    assign pop        = ldr_wr & ldr_ack & ~ack_q;
    // The ack must have dropped after the previous completion before a new request goes out.
    assign issue      = ~ldr_wr & (count != '0) & (~need_low | ~ldr_ack);
    assign head       = mem[rptr];
    assign ioctl_wait = (count >= CW'(DEPTH - 2));
    assign ldr_aen    = (state != S_IDLE) & ~ldr_done;

    always_comb begin
        flush_e    = {pend_tag, pend, 8'h00, 2'b10};
        n_push     = 2'd0;
        e0         = '0;
        e1         = '0;
        pend_v_n   = pend_v;
        pend_n     = pend;
        pend_tag_n = pend_tag;
        if (accept) begin
            if (!ioctl_addr[0]) begin
                if (pend_v && (pend_tag != byte_tag)) begin
                    n_push = 2'd1;
                    e0     = flush_e;
                end
                pend_v_n   = 1'b1;
                pend_n     = ioctl_dout;
                pend_tag_n = byte_tag;
            end else if (pend_v && (pend_tag == byte_tag)) begin
                n_push   = 2'd1;
                e0       = {byte_tag, pend, ioctl_dout, 2'b11};
                pend_v_n = 1'b0;
            end else if (pend_v) begin
                // Odd byte of a different word: orphaned even byte goes out first.
                n_push   = 2'd2;
                e0       = flush_e;
                e1       = {byte_tag, 8'h00, ioctl_dout, 2'b01};
                pend_v_n = 1'b0;
            end else begin
                n_push = 2'd1;
                e0     = {byte_tag, 8'h00, ioctl_dout, 2'b01};
            end
        end else if ((state == S_FLUSH) && pend_v) begin
            n_push   = 2'd1;
            e0       = flush_e;
            pend_v_n = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (n_push != 2'd0) mem[wptr] <= e0;
        if (n_push == 2'd2) mem[wptr + PW'(1)] <= e1;
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            pend_v   <= 1'b0;
            pend     <= '0;
            pend_tag <= '0;
            dl_q     <= 1'b0;
            ack_q    <= 1'b0;
            need_low <= 1'b0;
            ldr_wr   <= 1'b0;
            ldr_addr <= '0;
            ldr_wdat <= '0;
            ldr_be   <= '0;
        end else begin
            dl_q     <= ioctl_download;
            ack_q    <= ldr_ack;
            wptr     <= wptr + PW'(n_push);
            rptr     <= rptr + PW'(pop);
            count    <= count + CW'(n_push) - CW'(pop);
            pend_v   <= pend_v_n & ~(dl_start & (state != S_LOAD));
            pend     <= pend_n;
            pend_tag <= pend_tag_n;
            if (pop) begin
                ldr_wr   <= 1'b0;
                need_low <= 1'b1;
            end else if (!ldr_ack) begin
                need_low <= 1'b0;
            end
            if (issue) begin
                ldr_wr   <= 1'b1;
                ldr_addr <= {head[EW-1:18], 1'b0};
                ldr_wdat <= head[17:2];
                ldr_be   <= head[1:0];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            ldr_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dl_start) begin
                        state    <= S_LOAD;
                        ldr_done <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (dl_fall) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (dl_start) begin
                        state    <= S_LOAD;
                        ldr_done <= 1'b0;
                    end else if ((count == '0) && !ldr_wr) begin
                        state    <= S_DONE;
                        ldr_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (dl_start) begin
                        state    <= S_LOAD;
                        ldr_done <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LDR_CHECKSUM_EN
    logic sum_clr;
    assign sum_clr = dl_start & (state != S_LOAD) & (state != S_FLUSH);

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            ldr_sum <= '0;
        end else if (sum_clr) begin
            ldr_sum <= '0;
        end else if (pop) begin
            ldr_sum <= ldr_sum + (ldr_wdat & {{8{ldr_be[1]}}, {8{ldr_be[0]}}});
        end
    end
`endif

endmodule

// File: tb/tb_ioctl_ldr_bridge.sv
// Scoreboard bench for ioctl_ldr_bridge: expected loader writes are queued by the stimulus
// and compared by a monitor on each rising ldr_wr.
module tb_ioctl_ldr_bridge;
    localparam int DEPTH = 8;
    localparam int AW    = 20;

    logic          clk_sys = 1'b0;
    logic          rstn;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          ldr_aen;
    logic [AW-1:0] ldr_addr;
    logic [15:0]   ldr_wdat;
    logic [1:0]    ldr_be;
    logic          ldr_wr;
    logic          ldr_ack;
    logic          ldr_done;
`ifdef LDR_CHECKSUM_EN
    logic [15:0]   ldr_sum;
`endif

    ioctl_ldr_bridge #(.DEPTH(DEPTH), .AW(AW), .IDX(8'h00)) dut (
        .clk_sys(clk_sys),
        .rstn(rstn),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .ldr_aen(ldr_aen),
        .ldr_addr(ldr_addr),
        .ldr_wdat(ldr_wdat),
        .ldr_be(ldr_be),
        .ldr_wr(ldr_wr),
        .ldr_ack(ldr_ack),
        .ldr_done(ldr_done)
`ifdef LDR_CHECKSUM_EN
        ,
        .ldr_sum(ldr_sum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_total = 0;
    int n_pass  = 0;
    int n_rise  = 0;
    logic [AW+17:0] exp_q [$];
    logic ack_en    = 1'b1;
    logic ack_force = 1'b0;
    logic wr_prev   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    // Memory-side model: acknowledge one cycle after the request is seen.
    always @(posedge clk_sys) begin
        #1;
        ldr_ack = ack_force | (ack_en & ldr_wr);
    end

    always @(negedge clk_sys) begin
        if (rstn && ldr_wr && !wr_prev) begin
            n_rise++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write actual=%0h", {ldr_addr, ldr_wdat, ldr_be});
            end else begin
                check("ldr_write", {ldr_addr, ldr_wdat, ldr_be}, exp_q.pop_front());
            end
        end
        wr_prev = ldr_wr;
        if (rstn && dut.count > DEPTH) begin
            n_total++;
            $display("FAIL fifo_overflow actual=%0d limit=%0d", dut.count, DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic exp_push(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
        exp_q.push_back({a, d, be});
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d, input logic last);
        int n = 0;
        while (ioctl_wait && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_total++;
            $display("FAIL wait_timeout actual=1 expected=0");
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (last) ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!ldr_done && n < 200) begin
            tick();
            n++;
        end
        check(name, ldr_done, 1'b1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic basic_load(input logic lat_check);
        start_dl(8'h00);
        exp_push(20'h0, 16'h1234, 2'b11);
        exp_push(20'h2, 16'h5678, 2'b11);
        send(25'd0, 8'h12, 1'b0);
        send(25'd1, 8'h34, 1'b0);
        if (lat_check) begin
            @(negedge clk_sys);
            check("lat_n1_wr_low", ldr_wr, 1'b0);
            @(negedge clk_sys);
            check("lat_n2_wr_high", ldr_wr, 1'b1);
            tick();
        end
        send(25'd2, 8'h56, 1'b0);
        send(25'd3, 8'h78, 1'b0);
        end_dl();
        wait_done("t1_done");
`ifdef LDR_CHECKSUM_EN
        check("t1_checksum", ldr_sum, 16'h68AC);
`endif
    endtask

    initial begin
        int n;
        int r0;
        rstn           = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ldr_ack        = 1'b0;
        @(negedge clk_sys);
        check("reset_outputs", {ioctl_wait, ldr_aen, ldr_addr, ldr_wdat, ldr_be, ldr_wr, ldr_done}, '0);
        tick();
        rstn = 1'b1;
        tick();

        // Four-byte aligned download, with request latency checks.
        basic_load(1'b1);
        check("t1_aen_after_done", ldr_aen, 1'b0);

        // Odd length; download falls together with the final byte.
        start_dl(8'h00);
        check("t2_aen_in_load", ldr_aen, 1'b1);
        exp_push(20'h0, 16'hAABB, 2'b11);
        exp_push(20'h2, 16'hCC00, 2'b10);
        send(25'd0, 8'hAA, 1'b0);
        send(25'd1, 8'hBB, 1'b0);
        send(25'd2, 8'hCC, 1'b1);
        wait_done("t2_done");

        // Address jump: orphaned even byte then a lone odd byte.
        start_dl(8'h00);
        exp_push(20'h0, 16'hA500, 2'b10);
        exp_push(20'h4, 16'h005A, 2'b01);
        send(25'd0, 8'hA5, 1'b0);
        send(25'd5, 8'h5A, 1'b0);
        end_dl();
        wait_done("t3_done");

        // Back-pressure with ack held low.
        ack_en = 1'b0;
        start_dl(8'h00);
        for (int i = 0; i < 10; i++)
            exp_push(AW'(2 * i), {8'(8'h10 + 2 * i), 8'(8'h11 + 2 * i)}, 2'b11);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) check("t4_wait_at_5", ioctl_wait, 1'b0);
            if (i == 12) begin
                check("t4_wait_at_6", ioctl_wait, 1'b1);
                ack_en = 1'b1;
            end
            send(25'(i), 8'(8'h10 + i), 1'b0);
        end
        end_dl();
        wait_done("t4_done");

        // Wrong index: nothing happens, done stays set.
        r0 = n_rise;
        start_dl(8'h01);
        send(25'd0, 8'h11, 1'b0);
        send(25'd1, 8'h22, 1'b0);
        end_dl();
        repeat (5) tick();
        check("t5_no_write", n_rise, r0);
        check("t5_aen", ldr_aen, 1'b0);
        check("t5_done_kept", ldr_done, 1'b1);

        // Ack already high when the request rises: needs a fresh edge.
        ack_force = 1'b1;
        start_dl(8'h00);
        exp_push(20'h6, 16'h0102, 2'b11);
        send(25'd6, 8'h01, 1'b0);
        send(25'd7, 8'h02, 1'b0);
        end_dl();
        repeat (6) tick();
        check("t6_wr_held", ldr_wr, 1'b1);
        ack_en    = 1'b0;
        ack_force = 1'b0;
        repeat (3) tick();
        check("t6_wr_still_held", ldr_wr, 1'b1);
        ack_en = 1'b1;
        wait_done("t6_done");

        // Reset while a request is outstanding.
        ack_en = 1'b0;
        start_dl(8'h00);
        exp_push(20'h0, 16'h9988, 2'b11);
        send(25'd0, 8'h99, 1'b0);
        send(25'd1, 8'h88, 1'b0);
        n = 0;
        while (!ldr_wr && n < 20) begin
            tick();
            n++;
        end
        check("t7_wr_before_reset", ldr_wr, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("t7_reset_outputs", {ioctl_wait, ldr_aen, ldr_addr, ldr_wdat, ldr_be, ldr_wr, ldr_done}, '0);
        ioctl_download = 1'b0;
        exp_q.delete();
        ack_en = 1'b1;
        tick();
        rstn = 1'b1;
        tick();
        basic_load(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
